// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite / RCC definitions: default sizes and the
// command-queue FSM state type.
package ahb3lite_pkg;

    localparam int RCC_DEPTH_DEF  = 4;
    localparam int RCC_ADDR_W_DEF = 32;
    localparam int RCC_LEN_W_DEF  = 6;

    typedef enum logic {
        RCC_IDLE,
        RCC_BUSY
    } rcc_state_t;

endpackage

// File: rtl/rcc_cmd_fifo.sv
// Synchronous descriptor FIFO with flush; read data is the
// current head, consumed by pop.
module rcc_cmd_fifo
    import ahb3lite_pkg::*;
#(
    parameter int DEPTH = RCC_DEPTH_DEF,
    parameter int WIDTH = RCC_ADDR_W_DEF + RCC_LEN_W_DEF
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/rcc_cmd_queue.sv
// RCC DMA command queue: FIFO of CPU descriptors issued to the AHB master.
// Optional RCC_CMD_STATS_EN adds o_done_count and o_overflow.
module rcc_cmd_queue
    import ahb3lite_pkg::*;
#(
    parameter int DEPTH  = RCC_DEPTH_DEF,
    parameter int ADDR_W = RCC_ADDR_W_DEF,
    parameter int LEN_W  = RCC_LEN_W_DEF
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [ADDR_W-1:0]       i_cmd_addr,
    input  logic [LEN_W-1:0]        i_cmd_len,
    input  logic                    i_flush,
    input  logic                    i_CoreSystemStart,
    input  logic                    CoreSystem_Master_Done,
    output logic                    NewCommandOn,
    output logic [LEN_W-1:0]        o_RCC_BUFFER_LENGTH,
    output logic [ADDR_W/2-1:0]     o_RCC_DMA_ADDR_HIGH,
    output logic [ADDR_W/2-1:0]     o_RCC_DMA_ADDR_LOW,
    output logic [$clog2(DEPTH):0]  o_fifo_count,
    output logic                    o_fifo_full,
    output logic                    o_fifo_empty,
`ifdef RCC_CMD_STATS_EN
    output logic [15:0]             o_done_count,
    output logic                    o_overflow,
`endif
    output logic                    o_zero_len_drop
);

    localparam int W  = ADDR_W + LEN_W;
    localparam int HW = ADDR_W / 2;

    rcc_state_t state, state_nxt;

    logic             push_acc;
    logic             push_store;
    logic             issue;
    logic             retire;
    logic [W-1:0]     head;

    assign o_cmd_ready = !o_fifo_full && !i_flush;
    assign push_acc    = i_cmd_valid && o_cmd_ready;
    assign push_store  = push_acc && (i_cmd_len != '0);

    rcc_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .push    (push_store),
        .pop     (issue),
        .flush   (i_flush),
        .wr_data ({i_cmd_addr, i_cmd_len}),
        .rd_data (head),
        .count   (o_fifo_count),
        .full    (o_fifo_full),
        .empty   (o_fifo_empty)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= RCC_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RCC_IDLE: if (issue)  state_nxt = RCC_BUSY;
            RCC_BUSY: if (retire) state_nxt = RCC_IDLE;
        endcase
    end

    // Empty is the registered flag, so a same-cycle push is never popped.
    always_comb begin
        NewCommandOn = (state == RCC_BUSY);
        issue  = (state == RCC_IDLE) && i_CoreSystemStart &&
                 !o_fifo_empty && !i_flush;
        retire = (state == RCC_BUSY) && CoreSystem_Master_Done;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            o_RCC_BUFFER_LENGTH <= '0;
            o_RCC_DMA_ADDR_HIGH <= '0;
            o_RCC_DMA_ADDR_LOW  <= '0;
        end else if (issue) begin
            o_RCC_BUFFER_LENGTH <= head[LEN_W-1:0];
            o_RCC_DMA_ADDR_LOW  <= head[LEN_W +: HW];
            o_RCC_DMA_ADDR_HIGH <= head[LEN_W+HW +: HW];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) o_zero_len_drop <= 1'b0;
        else          o_zero_len_drop <= push_acc && (i_cmd_len == '0);
    end

`ifdef RCC_CMD_STATS_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            o_done_count <= '0;
            o_overflow   <= 1'b0;
        end else begin
            if (retire) o_done_count <= o_done_count + 16'd1;
            if (i_cmd_valid && o_fifo_full) o_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rcc_cmd_queue.sv
// Randomised and directed bench for rcc_cmd_queue against a
// queue-based reference model.
module tb_rcc_cmd_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 6;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b0;
    logic              i_cmd_valid = 1'b0;
    logic              o_cmd_ready;
    logic [ADDR_W-1:0] i_cmd_addr = '0;
    logic [LEN_W-1:0]  i_cmd_len = '0;
    logic              i_flush = 1'b0;
    logic              i_CoreSystemStart = 1'b0;
    logic              CoreSystem_Master_Done = 1'b0;
    logic              NewCommandOn;
    logic [LEN_W-1:0]  o_RCC_BUFFER_LENGTH;
    logic [15:0]       o_RCC_DMA_ADDR_HIGH;
    logic [15:0]       o_RCC_DMA_ADDR_LOW;
    logic [CW-1:0]     o_fifo_count;
    logic              o_fifo_full;
    logic              o_fifo_empty;
    logic              o_zero_len_drop;
`ifdef RCC_CMD_STATS_EN
    logic [15:0]       o_done_count;
    logic              o_overflow;
`endif

    rcc_cmd_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .HCLK                   (HCLK),
        .HRESETn                (HRESETn),
        .i_cmd_valid            (i_cmd_valid),
        .o_cmd_ready            (o_cmd_ready),
        .i_cmd_addr             (i_cmd_addr),
        .i_cmd_len              (i_cmd_len),
        .i_flush                (i_flush),
        .i_CoreSystemStart      (i_CoreSystemStart),
        .CoreSystem_Master_Done (CoreSystem_Master_Done),
        .NewCommandOn           (NewCommandOn),
        .o_RCC_BUFFER_LENGTH    (o_RCC_BUFFER_LENGTH),
        .o_RCC_DMA_ADDR_HIGH    (o_RCC_DMA_ADDR_HIGH),
        .o_RCC_DMA_ADDR_LOW     (o_RCC_DMA_ADDR_LOW),
        .o_fifo_count           (o_fifo_count),
        .o_fifo_full            (o_fifo_full),
        .o_fifo_empty           (o_fifo_empty),
`ifdef RCC_CMD_STATS_EN
        .o_done_count           (o_done_count),
        .o_overflow             (o_overflow),
`endif
        .o_zero_len_drop        (o_zero_len_drop)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } desc_t;

    desc_t q[$];
    bit    m_busy;
    desc_t m_out;
    bit    m_drop;
    int    m_done;
    bit    m_ovf;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 0;
        m_out  = '0;
        m_drop = 0;
        m_done = 0;
        m_ovf  = 0;
    endtask

    task automatic check_all();
        chk("new_cmd", 64'(NewCommandOn), 64'(m_busy));
        chk("len", 64'(o_RCC_BUFFER_LENGTH), 64'(m_out.len));
        chk("addr_hi", 64'(o_RCC_DMA_ADDR_HIGH), 64'(m_out.addr[31:16]));
        chk("addr_lo", 64'(o_RCC_DMA_ADDR_LOW), 64'(m_out.addr[15:0]));
        chk("count", 64'(o_fifo_count), 64'(q.size()));
        chk("full", 64'(o_fifo_full), 64'(q.size() == DEPTH));
        chk("empty", 64'(o_fifo_empty), 64'(q.size() == 0));
        chk("zdrop", 64'(o_zero_len_drop), 64'(m_drop));
`ifdef RCC_CMD_STATS_EN
        chk("done_cnt", 64'(o_done_count), 64'(m_done));
        chk("overflow", 64'(o_overflow), 64'(m_ovf));
`endif
    endtask

    // Called at a negedge; applies one cycle of inputs.
    task automatic step(bit v, logic [ADDR_W-1:0] a, logic [LEN_W-1:0] l,
                        bit fl, bit st, bit dn);
        bit full, acc, pop;
        i_cmd_valid = v;
        i_cmd_addr  = a;
        i_cmd_len   = l;
        i_flush     = fl;
        i_CoreSystemStart      = st;
        CoreSystem_Master_Done = dn;
        #1;
        chk("ready", 64'(o_cmd_ready), 64'((q.size() < DEPTH) && !fl));
        @(posedge HCLK);
        full = (q.size() == DEPTH);
        acc  = v && !full && !fl;
        pop  = !m_busy && st && (q.size() != 0) && !fl;
        if (v && full) m_ovf = 1;
        m_drop = acc && (l == 0);
        if (m_busy && dn) begin
            m_busy = 0;
            m_done = (m_done + 1) & 32'hFFFF;
        end else if (pop) begin
            m_busy = 1;
            m_out  = q[0];
        end
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc && l != 0) q.push_back('{addr: a, len: l});
        end
        @(negedge HCLK);
        check_all();
    endtask

    task automatic idle();
        step(0, '0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        #1;
        model_reset();
        chk("rst_new_cmd", 64'(NewCommandOn), 64'd0);
        chk("rst_count", 64'(o_fifo_count), 64'd0);
        chk("rst_empty", 64'(o_fifo_empty), 64'd1);
        chk("rst_ready", 64'(o_cmd_ready), 64'd1);
        chk("rst_len", 64'(o_RCC_BUFFER_LENGTH), 64'd0);
        chk("rst_addr", 64'({o_RCC_DMA_ADDR_HIGH, o_RCC_DMA_ADDR_LOW}), 64'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        bit v, fl, st, dn;
        logic [LEN_W-1:0] l;
        @(negedge HCLK);
        do_reset();
        @(negedge HCLK);

        // Basic issue with 1-cycle latency, then done
        step(1, 32'h1234_5678, 6'd8, 0, 0, 0);
        step(0, '0, '0, 0, 1, 0);
        chk("lit_new_cmd", 64'(NewCommandOn), 64'd1);
        chk("lit_hi", 64'(o_RCC_DMA_ADDR_HIGH), 64'h1234);
        chk("lit_lo", 64'(o_RCC_DMA_ADDR_LOW), 64'h5678);
        chk("lit_len", 64'(o_RCC_BUFFER_LENGTH), 64'd8);
        step(0, '0, '0, 0, 0, 1);
        chk("lit_done", 64'(NewCommandOn), 64'd0);
        chk("lit_hold_lo", 64'(o_RCC_DMA_ADDR_LOW), 64'h5678);

        // Fill past full, then drain across pointer wrap
        for (int i = 0; i < 5; i++)
            step(1, 32'hA000_0000 + i, 6'(i + 1), 0, 0, 0);
        chk("lit_full_cnt", 64'(o_fifo_count), 64'd4);
        chk("lit_full_rdy", 64'(o_cmd_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, '0, '0, 0, 1, 0);
            chk("lit_order", 64'(o_RCC_DMA_ADDR_LOW), 64'(i));
            chk("lit_order_len", 64'(o_RCC_BUFFER_LENGTH), 64'(i + 1));
            step(0, '0, '0, 0, 0, 1);
        end

        // Zero-length descriptor
        step(1, 32'hDEAD_BEEF, 6'd0, 0, 0, 0);
        chk("lit_zdrop", 64'(o_zero_len_drop), 64'd1);
        chk("lit_z_cnt", 64'(o_fifo_count), 64'd0);
        step(0, '0, '0, 0, 1, 0);
        chk("lit_z_noissue", 64'(NewCommandOn), 64'd0);
        chk("lit_zdrop_off", 64'(o_zero_len_drop), 64'd0);

        // Flush while busy
        for (int i = 0; i < 3; i++)
            step(1, 32'hB000_0010 + i, 6'd3, 0, 0, 0);
        step(0, '0, '0, 0, 1, 0);
        step(1, 32'hFFFF_FFFF, 6'd9, 1, 0, 0);
        chk("lit_fl_cnt", 64'(o_fifo_count), 64'd0);
        chk("lit_fl_busy", 64'(NewCommandOn), 64'd1);
        chk("lit_fl_lo", 64'(o_RCC_DMA_ADDR_LOW), 64'h0010);
        step(0, '0, '0, 0, 1, 1);
        chk("lit_fl_done", 64'(NewCommandOn), 64'd0);
        step(0, '0, '0, 0, 1, 0);
        chk("lit_fl_noissue", 64'(NewCommandOn), 64'd0);

        // Push + start on empty queue does not issue the new entry
        step(1, 32'hC0DE_0001, 6'd5, 0, 1, 0);
        chk("lit_same_cyc", 64'(NewCommandOn), 64'd0);
        step(0, '0, '0, 0, 1, 0);
        chk("lit_later", 64'(NewCommandOn), 64'd1);

        // Reset while busy
        @(negedge HCLK);
        #2;
        do_reset();
        idle();

`ifdef RCC_CMD_STATS_EN
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h0000_0100 + i, 6'd1, 0, 0, 0);
            step(0, '0, '0, 0, 1, 0);
            step(0, '0, '0, 0, 0, 1);
        end
        chk("lit_done_cnt", 64'(o_done_count), 64'd3);
        for (int i = 0; i < 5; i++)
            step(1, 32'h0000_0200 + i, 6'd2, 0, 0, 0);
        step(0, '0, '0, 0, 0, 0);
        chk("lit_ovf", 64'(o_overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, '0, '0, 0, 1, 0);
            step(0, '0, '0, 0, 0, 1);
        end
        chk("lit_ovf_sticky", 64'(o_overflow), 64'd1);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            v  = ($urandom_range(0, 1) == 1);
            l  = ($urandom_range(0, 5) == 0) ? '0 : LEN_W'($urandom);
            fl = ($urandom_range(0, 24) == 0);
            st = ($urandom_range(0, 2) == 0);
            dn = ($urandom_range(0, 3) == 0);
            step(v, $urandom, l, fl, st, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
